// File: rtl/instruction_mem_loader_pkg.sv
// Shared definitions for the instruction memory loader: geometry of the
// 64 x 39-bit program store and the loader FSM state encoding.
package instruction_mem_loader_pkg;

  localparam int unsigned DATA_W      = 39;
  localparam int unsigned ADDR_W      = 6;
  localparam int unsigned DEPTH       = 64;
  localparam int unsigned BYTES_PER_W = (DATA_W + 7) / 8;
  localparam int unsigned PACK_W      = BYTES_PER_W * 8;
  localparam int unsigned IDX_W       = 3;
  localparam int unsigned CNT_W       = 7;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    WRITE,
    DONE
  } state_t;

  function automatic logic count_legal(input logic [CNT_W-1:0] c);
    return (c != '0) && (c <= CNT_W'(DEPTH));
  endfunction

endpackage

// File: rtl/instruction_mem_loader_packer.sv
// Byte packer: shifts incoming bytes MSB-first into a 40-bit word and flags
// the transfer that completes the word.
module loader_byte_packer
  import instruction_mem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              shift_en,
  input  logic [7:0]        byte_in,
  output logic [PACK_W-1:0] word_next,
  output logic              word_full
);

  logic [PACK_W-1:0] word;
  logic [IDX_W-1:0]  byte_idx;

  // Value the shift register takes on this transfer, so the writer can
  // register it in the same edge without waiting a cycle.
  always_comb begin
    word_next = {word[PACK_W-9:0], byte_in};
    word_full = shift_en && (byte_idx == IDX_W'(BYTES_PER_W - 1));
  end

  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      word     <= '0;
      byte_idx <= '0;
    end else if (shift_en) begin
      word     <= word_next;
      byte_idx <= byte_idx + 1'b1;
    end
  end

endmodule

// File: rtl/instruction_mem_loader.sv
// Instruction memory loader: packs a host byte stream into 39-bit words and
// writes them to the program store at ascending addresses from 0.
module instruction_mem_loader
  import instruction_mem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [CNT_W-1:0]  word_count,
  input  logic [7:0]        byte_data,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              error
);

  state_t            state, next_state;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] count_m1;
  logic [CNT_W-1:0]  wc_m1;
  logic              start_acc, start_ok, last_word, transfer;
  logic [PACK_W-1:0] word_next;
  logic              word_full;

  logic              byte_ready_d, mem_we_d, busy_d, done_d, error_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_d;

  assign transfer  = byte_valid && byte_ready;
  assign start_acc = start && ((state == IDLE) || (state == DONE));
  assign start_ok  = start_acc && count_legal(word_count);
  assign last_word = (addr == count_m1);
  assign wc_m1     = word_count - 1'b1;

  loader_byte_packer u_packer (
    .clk       (clk),
    .reset     (reset),
    .clear     (start_acc || (state == WRITE)),
    .shift_en  (transfer),
    .byte_in   (byte_data),
    .word_next (word_next),
    .word_full (word_full)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      addr       <= '0;
      count_m1   <= '0;
      byte_ready <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      state      <= next_state;
      byte_ready <= byte_ready_d;
      mem_we     <= mem_we_d;
      mem_addr   <= mem_addr_d;
      mem_wdata  <= mem_wdata_d;
      busy       <= busy_d;
      done       <= done_d;
      error      <= error_d;
      if (start_ok) begin
        addr     <= '0;
        count_m1 <= wc_m1[ADDR_W-1:0];
      end else if ((state == WRITE) && !last_word) begin
        addr <= addr + 1'b1;
      end
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE, DONE: begin
        if (start_ok)       next_state = COLLECT;
        else if (start_acc) next_state = IDLE;
      end
      COLLECT: if (word_full) next_state = WRITE;
      WRITE:   next_state = last_word ? DONE : COLLECT;
      default: next_state = IDLE;
    endcase
  end

  // Outputs are registered from next_state so each one is valid in the
  // same cycle the FSM occupies the corresponding state.
  always_comb begin
    byte_ready_d = (next_state == COLLECT);
    mem_we_d     = (next_state == WRITE);
    busy_d       = (next_state == COLLECT) || (next_state == WRITE);
    done_d       = (next_state == DONE);
    mem_addr_d   = mem_addr;
    mem_wdata_d  = mem_wdata;
    error_d      = error;
    if (start_acc) begin
      error_d = !start_ok;
    end else if (next_state == WRITE) begin
      mem_addr_d  = addr;
      mem_wdata_d = word_next[DATA_W-1:0];
      if (word_next[PACK_W-1]) error_d = 1'b1;
    end
  end

endmodule

// File: tb/tb_instruction_mem_loader.sv
// Scoreboard bench for instruction_mem_loader: stimulus pushes expected
// writes, a negedge monitor pops and compares every mem_we pulse.
module tb_instruction_mem_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [6:0]  word_count;
  logic [7:0]  byte_data;
  logic        byte_valid;
  logic        byte_ready;
  logic        mem_we;
  logic [5:0]  mem_addr;
  logic [38:0] mem_wdata;
  logic        busy;
  logic        done;
  logic        error;

  typedef struct {
    logic [5:0]  a;
    logic [38:0] d;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   errors   = 0;
  int   n_writes = 0;

  always #5 clk = ~clk;

  instruction_mem_loader dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .word_count (word_count),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (mem_we) begin
      exp_t e;
      n_writes++;
      if (exp_q.size() == 0) begin
        check("unexpected_write", {58'd0, mem_addr}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("write_addr", {58'd0, mem_addr}, {58'd0, e.a});
        check("write_data", {25'd0, mem_wdata}, {25'd0, e.d});
      end
    end
  end

  task automatic push(input logic [5:0] a, input logic [38:0] d);
    exp_t e;
    e.a = a;
    e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic do_start(input logic [6:0] c);
    start      = 1'b1;
    word_count = c;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int g = 0;
    byte_data  = b;
    byte_valid = 1'b1;
    while (!byte_ready && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (g >= 200) check("byte_ready_timeout", 64'd0, 64'd1);
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [38:0] w, input int max_gap);
    logic [39:0] pk;
    pk = {1'b0, w};
    for (int i = 0; i < 5; i++) begin
      repeat ($urandom_range(0, max_gap)) @(negedge clk);
      send_byte(pk[39-8*i -: 8]);
    end
  endtask

  task automatic wait_done();
    int g = 0;
    while (!done && g < 500) begin
      @(negedge clk);
      g++;
    end
    check("done_reached", {63'd0, done}, 64'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_byte_ready"}, {63'd0, byte_ready}, 64'd0);
    check({tag, "_mem_we"},     {63'd0, mem_we},     64'd0);
    check({tag, "_mem_addr"},   {58'd0, mem_addr},   64'd0);
    check({tag, "_mem_wdata"},  {25'd0, mem_wdata},  64'd0);
    check({tag, "_busy"},       {63'd0, busy},       64'd0);
    check({tag, "_done"},       {63'd0, done},       64'd0);
    check({tag, "_error"},      {63'd0, error},      64'd0);
  endtask

  logic [38:0] words[64];
  int          base;

  initial begin
    reset      = 1'b0;
    start      = 1'b0;
    word_count = '0;
    byte_data  = '0;
    byte_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b1;
    @(negedge clk);

    // Single word, fixed bytes
    push(6'd0, 39'h00_1234_5678);
    do_start(7'd1);
    check("collect_busy", {63'd0, busy}, 64'd1);
    check("collect_ready", {63'd0, byte_ready}, 64'd1);
    send_byte(8'h00);
    send_byte(8'h12);
    send_byte(8'h34);
    send_byte(8'h56);
    send_byte(8'h78);
    wait_done();
    check("one_error", {63'd0, error}, 64'd0);
    check("one_busy", {63'd0, busy}, 64'd0);
    check("one_ready", {63'd0, byte_ready}, 64'd0);
    check("one_queue", exp_q.size(), 64'd0);

    // Illegal counts
    do_start(7'd0);
    @(negedge clk);
    check("cnt0_error", {63'd0, error}, 64'd1);
    check("cnt0_busy", {63'd0, busy}, 64'd0);
    check("cnt0_ready", {63'd0, byte_ready}, 64'd0);
    check("cnt0_done", {63'd0, done}, 64'd0);
    do_start(7'd65);
    byte_valid = 1'b1;
    repeat (4) @(negedge clk);
    byte_valid = 1'b0;
    check("cnt65_error", {63'd0, error}, 64'd1);
    check("cnt65_busy", {63'd0, busy}, 64'd0);
    check("cnt65_ready", {63'd0, byte_ready}, 64'd0);

    // Pad bit set: bit 39 dropped, error raised
    push(6'd0, 39'h00_0000_0000);
    do_start(7'd1);
    check("pad_error_cleared", {63'd0, error}, 64'd0);
    send_byte(8'h80);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    wait_done();
    check("pad_error", {63'd0, error}, 64'd1);

    // Start during a load is ignored
    base = n_writes;
    push(6'd0, 39'h0A_1122_3344);
    push(6'd1, 39'h55_6677_8899);
    push(6'd2, 39'h7F_FFFF_FFFF);
    do_start(7'd3);
    send_word(39'h0A_1122_3344, 0);
    do_start(7'd5);
    send_word(39'h55_6677_8899, 1);
    do_start(7'd1);
    send_word(39'h7F_FFFF_FFFF, 0);
    wait_done();
    repeat (20) @(negedge clk);
    check("ignore_writes", n_writes - base, 64'd3);
    check("ignore_done_held", {63'd0, done}, 64'd1);
    check("ignore_error", {63'd0, error}, 64'd0);

    // Reset mid-load after 3 bytes of the second word
    base = n_writes;
    push(6'd0, 39'h12_3456_789A);
    do_start(7'd4);
    send_word(39'h12_3456_789A, 0);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    reset = 1'b0;
    @(negedge clk);
    check_all_zero("midreset");
    reset      = 1'b1;
    byte_valid = 1'b1;
    byte_data  = 8'h04;
    repeat (20) @(negedge clk);
    byte_valid = 1'b0;
    check("midreset_writes", n_writes - base, 64'd1);
    check_all_zero("post_reset");

    // Full 64-word load with random data and byte gaps
    base = n_writes;
    for (int i = 0; i < 64; i++) begin
      logic [63:0] r;
      r        = {$urandom(), $urandom()};
      words[i] = r[38:0];
      push(6'(i), words[i]);
    end
    do_start(7'd64);
    for (int i = 0; i < 64; i++) send_word(words[i], 2);
    wait_done();
    check("full_writes", n_writes - base, 64'd64);
    check("full_error", {63'd0, error}, 64'd0);
    check("full_busy", {63'd0, busy}, 64'd0);
    check("full_last_addr", {58'd0, mem_addr}, 64'd63);
    check("full_queue", exp_q.size(), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
